// File: rtl/id_alu_stage_pkg.sv
// Shared decode constants for the ID stage of the integer ALU path:
// opcodes, funct3/funct7 values, ALU opcode encoding and enable levels.
package id_alu_stage_pkg;

    localparam logic [6:0] INST_TYPE_R = 7'b0110011;
    localparam logic [6:0] INST_TYPE_I = 7'b0010011;

    localparam logic [2:0] INST_ADD_SUB = 3'b000;
    localparam logic [2:0] INST_SLL     = 3'b001;
    localparam logic [2:0] INST_SLT     = 3'b010;
    localparam logic [2:0] INST_SLTU    = 3'b011;
    localparam logic [2:0] INST_XOR     = 3'b100;
    localparam logic [2:0] INST_SR      = 3'b101;
    localparam logic [2:0] INST_OR      = 3'b110;
    localparam logic [2:0] INST_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;

    localparam logic [31:0] ZERO          = 32'h0;
    localparam logic [4:0]  ZERO_REG      = 5'd0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        READ_ENABLE   = 1'b1;
    localparam logic        READ_DISABLE  = 1'b0;

    // Base ALU op for a funct3; SUB/SRA are selected later from funct7.
    function automatic logic [3:0] alu_base(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3)
            INST_ADD_SUB: op = ALU_OP_ADD;
            INST_SLL:     op = ALU_OP_SLL;
            INST_SLT:     op = ALU_OP_SLT;
            INST_SLTU:    op = ALU_OP_SLTU;
            INST_XOR:     op = ALU_OP_XOR;
            INST_SR:      op = ALU_OP_SRL;
            INST_OR:      op = ALU_OP_OR;
            default:      op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_alu_decode.sv
// Combinational decode of OP / OP-IMM instructions: register fields,
// immediate, read enables, ALU opcode, writeback enable and illegal flag.
module id_alu_decode
    import id_alu_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RDATA_WIDTH = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]  inst_i,
    output logic [RADDR_WIDTH-1:0] rs1_o,
    output logic [RADDR_WIDTH-1:0] rs2_o,
    output logic [RADDR_WIDTH-1:0] rd_o,
    output logic                   re1_o,
    output logic                   re2_o,
    output logic                   use_imm_o,
    output logic [RDATA_WIDTH-1:0] imm_o,
    output logic [3:0]             alu_op_o,
    output logic                   we_o,
    output logic                   illegal_o
);

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [RDATA_WIDTH-1:0] simm;
    logic [RDATA_WIDTH-1:0] shamt;
    logic                   re1;
    logic                   re2;
    logic                   we;
    logic                   illegal;
    logic [3:0]             alu_op;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd_o   = inst_i[7 +: RADDR_WIDTH];
    assign rs1_o  = inst_i[15 +: RADDR_WIDTH];
    assign rs2_o  = inst_i[20 +: RADDR_WIDTH];
    assign simm   = {{(RDATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
    assign shamt  = {{(RDATA_WIDTH-5){1'b0}}, inst_i[24:20]};

    always_comb begin
        re1       = READ_DISABLE;
        re2       = READ_DISABLE;
        we        = WRITE_DISABLE;
        use_imm_o = 1'b0;
        imm_o     = '0;
        alu_op    = ALU_OP_ADD;
        illegal   = 1'b1;
        case (opcode)
            INST_TYPE_R: begin
                re1    = READ_ENABLE;
                re2    = READ_ENABLE;
                we     = WRITE_ENABLE;
                alu_op = alu_base(funct3);
                if (funct7 == FUNCT7_BASE) begin
                    illegal = 1'b0;
                end else if (funct7 == FUNCT7_ALT && funct3 == INST_ADD_SUB) begin
                    illegal = 1'b0;
                    alu_op  = ALU_OP_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == INST_SR) begin
                    illegal = 1'b0;
                    alu_op  = ALU_OP_SRA;
                end
            end
            INST_TYPE_I: begin
                re1       = READ_ENABLE;
                we        = WRITE_ENABLE;
                use_imm_o = 1'b1;
                alu_op    = alu_base(funct3);
                illegal   = 1'b0;
                imm_o     = simm;
                // Shifts carry a 5-bit shamt; the upper bits act as funct7.
                if (funct3 == INST_SLL || funct3 == INST_SR) begin
                    imm_o = shamt;
                    if (funct3 == INST_SR && funct7 == FUNCT7_ALT) begin
                        alu_op = ALU_OP_SRA;
                    end else if (funct7 != FUNCT7_BASE) begin
                        illegal = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // An illegal slot reads nothing, so it can never cause a load-use stall.
    assign re1_o     = re1 & ~illegal;
    assign re2_o     = re2 & ~illegal;
    assign we_o      = we & ~illegal;
    assign alu_op_o  = illegal ? ALU_OP_ADD : alu_op;
    assign illegal_o = illegal;

endmodule

// File: rtl/id_alu_stage.sv
// Registered ID stage: decode, EX/MEM bypass, load-use stall and a
// valid/ready pipeline register feeding EX.
module id_alu_stage
    import id_alu_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RDATA_WIDTH = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  inst_i,
    input  logic                   inst_valid_i,
    output logic                   inst_ready_o,
    output logic [RADDR_WIDTH-1:0] reg1_raddr_o,
    output logic [RADDR_WIDTH-1:0] reg2_raddr_o,
    output logic                   reg1_re_o,
    output logic                   reg2_re_o,
    input  logic [RDATA_WIDTH-1:0] reg1_rdata_i,
    input  logic [RDATA_WIDTH-1:0] reg2_rdata_i,
    input  logic                   ex_we_i,
    input  logic [RADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [RDATA_WIDTH-1:0] ex_wdata_i,
    input  logic                   ex_is_load_i,
    input  logic                   mem_we_i,
    input  logic [RADDR_WIDTH-1:0] mem_waddr_i,
    input  logic [RDATA_WIDTH-1:0] mem_wdata_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [RDATA_WIDTH-1:0] op1_o,
    output logic [RDATA_WIDTH-1:0] op2_o,
    output logic [3:0]             alu_op_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   illegal_o
);

    logic [RADDR_WIDTH-1:0] rs1;
    logic [RADDR_WIDTH-1:0] rs2;
    logic [RADDR_WIDTH-1:0] rd;
    logic                   re1;
    logic                   re2;
    logic                   use_imm;
    logic [RDATA_WIDTH-1:0] imm;
    logic [3:0]             dec_alu_op;
    logic                   dec_we;
    logic                   dec_illegal;

    id_alu_decode #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RDATA_WIDTH (RDATA_WIDTH),
        .RADDR_WIDTH (RADDR_WIDTH)
    ) u_decode (
        .inst_i    (inst_i),
        .rs1_o     (rs1),
        .rs2_o     (rs2),
        .rd_o      (rd),
        .re1_o     (re1),
        .re2_o     (re2),
        .use_imm_o (use_imm),
        .imm_o     (imm),
        .alu_op_o  (dec_alu_op),
        .we_o      (dec_we),
        .illegal_o (dec_illegal)
    );

    assign reg1_raddr_o = rs1;
    assign reg2_raddr_o = rs2;
    assign reg1_re_o    = re1;
    assign reg2_re_o    = re2;

    // EX beats MEM; there is no WB path because the regfile writes first.
    function automatic logic [RDATA_WIDTH-1:0] bypass(
        input logic [RADDR_WIDTH-1:0] rs,
        input logic [RDATA_WIDTH-1:0] rf_data,
        input logic                   ex_we,
        input logic [RADDR_WIDTH-1:0] ex_waddr,
        input logic [RDATA_WIDTH-1:0] ex_wdata,
        input logic                   mem_we,
        input logic [RADDR_WIDTH-1:0] mem_waddr,
        input logic [RDATA_WIDTH-1:0] mem_wdata
    );
        logic [RDATA_WIDTH-1:0] val;
        if (rs == RADDR_WIDTH'(ZERO_REG))            val = '0;
        else if (ex_we && ex_waddr == rs)           val = ex_wdata;
        else if (mem_we && mem_waddr == rs)         val = mem_wdata;
        else                                        val = rf_data;
        return val;
    endfunction

    logic [RDATA_WIDTH-1:0] src1;
    logic [RDATA_WIDTH-1:0] src2;
    logic                   hazard;
    logic                   load;

    assign src1 = bypass(rs1, reg1_rdata_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                         mem_we_i, mem_waddr_i, mem_wdata_i);
    assign src2 = bypass(rs2, reg2_rdata_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                         mem_we_i, mem_waddr_i, mem_wdata_i);

    assign hazard = ex_is_load_i & ex_we_i &
                    ((re1 & (rs1 != '0) & (ex_waddr_i == rs1)) |
                     (re2 & (rs2 != '0) & (ex_waddr_i == rs2)));

    logic                   out_valid_q, out_valid_d;
    logic [RDATA_WIDTH-1:0] op1_q, op1_d;
    logic [RDATA_WIDTH-1:0] op2_q, op2_d;
    logic [3:0]             alu_op_q, alu_op_d;
    logic                   reg_we_q, reg_we_d;
    logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
    logic                   illegal_q, illegal_d;

    assign load         = out_ready_i | ~out_valid_q;
    assign inst_ready_o = flush_i | (load & ~hazard);

    always_comb begin
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_op_d    = alu_op_q;
        reg_we_d    = reg_we_q;
        reg_waddr_d = reg_waddr_q;
        illegal_d   = illegal_q;
        if (flush_i || load) begin
            // Bubbles and flushed slots load all-zero so EX sees clean fields.
            out_valid_d = inst_valid_i & ~hazard & ~flush_i;
            op1_d       = '0;
            op2_d       = '0;
            alu_op_d    = ALU_OP_ADD;
            reg_we_d    = WRITE_DISABLE;
            reg_waddr_d = '0;
            illegal_d   = 1'b0;
            if (out_valid_d) begin
                illegal_d = dec_illegal;
                if (!dec_illegal) begin
                    op1_d       = src1;
                    op2_d       = use_imm ? imm : src2;
                    alu_op_d    = dec_alu_op;
                    reg_we_d    = dec_we;
                    reg_waddr_d = rd;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            alu_op_q    <= ALU_OP_ADD;
            reg_we_q    <= WRITE_DISABLE;
            reg_waddr_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_op_q    <= alu_op_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;
    assign alu_op_o    = alu_op_q;
    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign illegal_o   = illegal_q;

endmodule

// File: doc/id_alu_stage.md
# id_alu_stage

Registered instruction-decode stage for the integer ALU path of the core. It sits between the fetch buffer and EX. It decodes OP (R-type) and OP-IMM (I-type) instructions and reads the register file. It resolves operands with EX/MEM bypassing, stalls on load-use hazards, and presents a valid/ready-handshaked pipeline register to EX.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: instruction width.
- `RDATA_WIDTH`, default 32: register/operand width (XLEN).
- `RADDR_WIDTH`, default 5: register address width.

Ports:
- `clk` in 1: the block's single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `inst_i` in DATA_WIDTH: instruction from fetch.
- `inst_valid_i` in 1, `inst_ready_o` out 1: fetch handshake. The instruction is consumed when both are 1.
- `reg1_raddr_o`, `reg2_raddr_o` out RADDR_WIDTH: register-file read addresses (combinational).
- `reg1_re_o`, `reg2_re_o` out 1: register-file read enables (combinational).
- `reg1_rdata_i`, `reg2_rdata_i` in RDATA_WIDTH: register-file read data, same cycle as the address.
- `ex_we_i` in 1, `ex_waddr_i` in RADDR_WIDTH, `ex_wdata_i` in RDATA_WIDTH, `ex_is_load_i` in 1: EX-stage destination and result.
- `mem_we_i` in 1, `mem_waddr_i` in RADDR_WIDTH, `mem_wdata_i` in RDATA_WIDTH: MEM-stage destination and result.
- `flush_i` in 1: kill the held and incoming instruction (branch redirect).
- `out_valid_o` out 1, `out_ready_i` in 1: EX handshake.
- `op1_o`, `op2_o` out RDATA_WIDTH: registered operands.
- `alu_op_o` out 4: registered ALU opcode.
- `reg_we_o` out 1, `reg_waddr_o` out RADDR_WIDTH: registered writeback control.
- `illegal_o` out 1: registered. Set to 1 for one accepted slot on an unsupported encoding.

## Operation
- Decoded opcodes: 0110011 (OP) and 0010011 (OP-IMM). Any other opcode is illegal.
- ALU opcode encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- OP instructions:
  - funct7=0000000 is valid for all funct3.
  - funct7=0100000 is valid only for funct3 000 (SUB) and funct3 101 (SRA).
  - Any other funct7 is illegal.
  - op1 = rs1 value, op2 = rs2 value. Both read enables are 1.
- OP-IMM instructions:
  - op2 = inst[31:20] sign-extended to RDATA_WIDTH. Only reg1_re_o is 1.
  - SLLI/SRLI/SRAI: op2 = zero-extended shamt inst[24:20].
  - SLLI requires inst[31:25]=0000000.
  - funct3 101 decodes as SRLI when inst[31:25]=0000000, as SRAI when inst[31:25]=0100000, and is illegal otherwise.
- Illegal instruction: registered as a bubble with reg_we_o=0, op1_o/op2_o=0, alu_op_o=0, illegal_o=1, out_valid_o=1. EX raises the trap.
- Operand select per source, in priority order:
  1. rs==0 gives 0.
  2. ex_we_i with ex_waddr_i==rs gives ex_wdata_i.
  3. mem_we_i with mem_waddr_i==rs gives mem_wdata_i.
  4. Otherwise the register-file data.
- Load-use hazard:
  - Condition: ex_is_load_i & ex_we_i & ex_waddr_i==rs & rs≠0, for any source that is actually read.
  - Response: inst_ready_o=0, and a bubble (out_valid_o=0) is inserted when the output register loads.
- Output register load enable: `load = out_ready_i | ~out_valid_o`.
- inst_ready_o = load & ~hazard, or 1 when flush_i=1.
- Next out_valid_o = inst_valid_i & ~hazard & ~flush_i, applied when load=1.
- Flush:
  - flush_i has priority over hazard and over the hold.
  - Next cycle out_valid_o=0 and illegal_o=0.
  - The incoming instruction is accepted and discarded.

## Timing
- Reset (rst_n=0, asynchronous): out_valid_o=0, op1_o=0, op2_o=0, alu_op_o=0, reg_we_o=0, reg_waddr_o=0, illegal_o=0.
- Reset gives no guarantee on combinational outputs: inst_ready_o, raddr, re.
- Latency: 1 cycle from handshake to out_valid_o. Throughput is 1 instruction per cycle when there is no stall.
- While out_valid_o=1 and out_ready_i=0, all registered outputs hold stable.
- Bypass data is sampled in the same cycle as the register-file read. There is no WB bypass: the register file writes before it reads.
- Simultaneous EX and MEM match on the same rs: EX wins.
- A hazard persists for exactly one cycle per load, because the load leaves EX.
- Reset mid-stall: the held instruction is lost and fetch replays it.

## Structure
- The shared `defines` file holds:
  - opcode constants: INST_TYPE_R, INST_TYPE_I;
  - funct3 constants: INST_ADD_SUB … INST_AND;
  - ALU_OP_* codes;
  - ZERO, ZERO_REG, WRITE_ENABLE/DISABLE, READ_ENABLE/DISABLE.
- Sub-module `id_alu_decode` is purely combinational and covers opcode, funct3 and funct7 decode, the immediate, the read enables, alu_op and illegal.
- The top level holds the bypass muxes, the hazard logic, the handshake and the output register.

## Test plan
- ADD x3,x1,x2 with regfile x1=5, x2=7, no bypass → next cycle out_valid_o=1, op1=5, op2=7, alu_op=0, reg_waddr=3, reg_we=1.
- SRAI x4,x1,3 (inst[31:25]=0100000) → op2=3, alu_op=7. ADDI x4,x1,-1 → op2=0xFFFFFFFF, reg2_re_o=0.
- SUB x5,x1,x1 with ex_waddr=1, ex_wdata=9 and mem_waddr=1, mem_wdata=4 → op1=op2=9 (EX priority). Same instruction with rs1=x0 → op1=0.
- ex_is_load_i=1, ex_waddr=2, then ADD x6,x1,x2 → inst_ready_o=0 for 1 cycle and one bubble. Next cycle the instruction issues with the MEM-bypassed value.
- out_ready_i=0 for 3 cycles with out_valid_o=1 → outputs stable and inst_ready_o=0. Then flush_i=1 → out_valid_o=0 next cycle.
- OP with funct7=0100000, funct3=001 → out_valid_o=1, illegal_o=1, reg_we_o=0. Opcode 0000011 → illegal_o=1.
